// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared FSM encoding and port indices for the RAM port arbiter
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic PORT_DATA  = 1'b0;
  localparam logic PORT_FETCH = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter2.sv
// rtl/ram_port_arbiter_rr_arbiter2.sv - two-way round-robin winner select
module rr_arbiter2
  import ram_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  // On a tie the port that did not own the last transaction wins.
  always_comb begin
    valid  = |req;
    winner = PORT_DATA;
    if (req == 2'b11) begin
      winner = ~last;
    end else if (req[1]) begin
      winner = PORT_FETCH;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares one single-port RAM between data-memory and fetch requesters
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_done,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_done,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_rden,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  busy,
  output logic                  grant
);

  state_t                state;
  logic                  win_valid;
  logic                  win;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  rr_arbiter2 u_rr_arbiter2 (
    .req    ({p1_req, p0_req}),
    .last   (grant),
    .valid  (win_valid),
    .winner (win)
  );

  assign sel_we    = (win == PORT_FETCH) ? p1_we    : p0_we;
  assign sel_addr  = (win == PORT_FETCH) ? p1_addr  : p0_addr;
  assign sel_wdata = (win == PORT_FETCH) ? p1_wdata : p0_wdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ram_rden    <= 1'b0;
      ram_wren    <= 1'b0;
      p0_done     <= 1'b0;
      p1_done     <= 1'b0;
      busy        <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
      grant       <= PORT_FETCH;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            grant       <= win;
            ram_address <= sel_addr;
            ram_data    <= sel_wdata;
            ram_wren    <= sel_we;
            ram_rden    <= ~sel_we;
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          // Strobe lives for this cycle only; writes need no capture slot.
          ram_rden <= 1'b0;
          ram_wren <= 1'b0;
          if (ram_rden) begin
            state <= CAPTURE;
          end else begin
            state <= DONE;
            if (grant == PORT_FETCH) p1_done <= 1'b1;
            else                     p0_done <= 1'b1;
          end
        end
        CAPTURE: begin
          // ram_q is only sampled here, so a floating bus never reaches rdata.
          if (grant == PORT_FETCH) begin
            p1_rdata <= ram_q;
            p1_done  <= 1'b1;
          end else begin
            p0_rdata <= ram_q;
            p0_done  <= 1'b1;
          end
          state <= DONE;
        end
        DONE: begin
          p0_done <= 1'b0;
          p1_done <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter with RAM model and scoreboard
module tb_ram_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 20;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          p0_req = 1'b0, p0_we = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          p0_done, p1_done;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_rden, ram_wren, busy, grant;
  wire  [DW-1:0] ram_q;

  always #5 clock = ~clock;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_done(p1_done), .p1_rdata(p1_rdata),
    .ram_address(ram_address), .ram_data(ram_data),
    .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_q(ram_q),
    .busy(busy), .grant(grant)
  );

  // Single-port RAM model: registered read, bus floats when not reading.
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] q_reg = '0;
  logic          q_vld = 1'b0;
  always @(posedge clock) begin
    q_vld <= ram_rden;
    if (ram_rden) q_reg <= mem.exists(ram_address) ? mem[ram_address] : '0;
    if (ram_wren) mem[ram_address] = ram_data;
  end
  assign ram_q = q_vld ? q_reg : 'z;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [DW-1:0] last_rd[2] = '{16'h0, 16'h0};
  logic [AW-1:0] strobe_addr = '0;
  logic [DW-1:0] strobe_data = '0;
  int            strobe_cnt = 0;
  int            done0_cnt = 0;
  int            done1_cnt = 0;
  logic          tb_grant = 1'b1;

  task automatic push(input int p, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    exp_t e;
    e.we = we; e.addr = addr; e.data = data;
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic sb_pop(input int p);
    exp_t          e;
    logic [DW-1:0] own, other;
    int            sz;
    sz = (p == 0) ? q0.size() : q1.size();
    check($sformatf("p%0d_sb_nonempty", p), 32'(sz > 0), 32'd1);
    if (sz > 0) begin
      if (p == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      own   = (p == 0) ? p0_rdata : p1_rdata;
      other = (p == 0) ? p1_rdata : p0_rdata;
      check($sformatf("p%0d_ram_addr", p), 32'(strobe_addr), 32'(e.addr));
      if (e.we) begin
        check($sformatf("p%0d_wr_data", p), 32'(strobe_data), 32'(e.data));
      end else begin
        check($sformatf("p%0d_rd_data", p), 32'(own), 32'(e.data));
        last_rd[p] = e.data;
      end
      check($sformatf("p%0d_other_rdata", 1 - p), 32'(other), 32'(last_rd[1 - p]));
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (ram_rden || ram_wren) begin
        strobe_cnt++;
        strobe_addr = ram_address;
        strobe_data = ram_data;
        check("strobe_onehot", 32'(ram_rden ^ ram_wren), 32'd1);
        check("strobe_busy", 32'(busy), 32'd1);
      end
      if (p0_done) begin
        done0_cnt++;
        check("done_excl", 32'(p1_done), 32'd0);
        sb_pop(0);
      end
      if (p1_done) begin
        done1_cnt++;
        sb_pop(1);
      end
    end
  end

  task automatic drive(input int p, input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (p == 0) begin p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; end
    else        begin p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; end
  endtask

  task automatic do_txn(input int p, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd, input int exp_lat);
    int lat;
    push(p, we, addr, we ? wdata : exp_rd);
    @(posedge clock); #1;
    drive(p, 1'b1, we, addr, wdata);
    @(posedge clock);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if ((p == 0) ? p0_done : p1_done) begin lat = k; break; end
    end
    check($sformatf("p%0d_latency", p), 32'(lat), 32'(exp_lat));
    @(posedge clock); #1;
    drive(p, 1'b0, 1'b0, addr, wdata);
    tb_grant = (p == 1);
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    tb_grant = 1'b1;
  endtask

  // Port 0 writes 0x1234 to 0x5 while port 1 reads 0x5; order comes from the bench's RR pointer.
  task automatic interleave();
    logic          w;
    logic [DW-1:0] exp1;
    int            first, n;
    logic          d0, d1;
    w    = ~tb_grant;
    exp1 = (w == 1'b0) ? 16'h1234 : 16'h0BAD;
    mem[20'h00005] = 16'h0BAD;
    push(0, 1'b1, 20'h00005, 16'h1234);
    push(1, 1'b0, 20'h00005, exp1);
    @(posedge clock); #1;
    drive(0, 1'b1, 1'b1, 20'h00005, 16'h1234);
    drive(1, 1'b1, 1'b0, 20'h00005, 16'h0000);
    first = -1; n = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      d0 = p0_done; d1 = p1_done;
      if ((d0 || d1) && first < 0) first = d1 ? 1 : 0;
      n += int'(d0) + int'(d1);
      @(posedge clock); #1;
      if (d0) drive(0, 1'b0, 1'b0, 20'h00005, 16'h0000);
      if (d1) drive(1, 1'b0, 1'b0, 20'h00005, 16'h0000);
      if (n >= 2) break;
    end
    check("il_first", 32'(first), 32'(w));
    check("il_count", 32'(n), 32'd2);
    tb_grant = ~w;
  endtask

  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            lat;
  } vec_t;

  vec_t          vecs[8];
  logic [DW-1:0] bb[8];
  int            order[$];
  int            sc, d0c, prev;

  initial begin
    vecs[0] = '{0, 1'b1, 20'h00010, 16'hBEEF, 16'h0000, 2};
    vecs[1] = '{0, 1'b0, 20'h00010, 16'h0000, 16'hBEEF, 3};
    vecs[2] = '{1, 1'b1, 20'hFFFFF, 16'h1357, 16'h0000, 2};
    vecs[3] = '{1, 1'b0, 20'hFFFFF, 16'h0000, 16'h1357, 3};
    vecs[4] = '{0, 1'b1, 20'h00000, 16'hA5A5, 16'h0000, 2};
    vecs[5] = '{1, 1'b0, 20'h00000, 16'h0000, 16'hA5A5, 3};
    vecs[6] = '{0, 1'b0, 20'h00010, 16'h0000, 16'hBEEF, 3};
    vecs[7] = '{1, 1'b0, 20'h00010, 16'h0000, 16'hBEEF, 3};

    // Reset held with random inputs.
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      drive(0, 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
      drive(1, 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
    end
    @(negedge clock);
    check("rst_outputs", 32'({p0_done, p1_done, busy, ram_rden, ram_wren}), 32'd0);
    check("rst_ram_addr", 32'(ram_address), 32'd0);
    check("rst_ram_data", 32'(ram_data), 32'd0);
    check("rst_rdata", 32'({p0_rdata, p1_rdata}), 32'd0);
    check("rst_grant", 32'(grant), 32'd1);
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(posedge clock); #1 reset = 1'b0;
    sc = strobe_cnt;
    repeat (10) @(negedge clock);
    check("idle_no_strobe", 32'(strobe_cnt - sc), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Table-driven single-port transactions.
    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].lat);
    end

    // Simultaneous reads after reset: port 0 first, then strict alternation.
    pulse_reset();
    mem[20'h00001] = 16'h1111;
    mem[20'h00002] = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      push(0, 1'b0, 20'h00001, 16'h1111);
      push(1, 1'b0, 20'h00002, 16'h2222);
    end
    @(posedge clock); #1;
    drive(0, 1'b1, 1'b0, 20'h00001, '0);
    drive(1, 1'b1, 1'b0, 20'h00002, '0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (p0_done) order.push_back(0);
      if (p1_done) order.push_back(1);
      if (order.size() >= 6) break;
    end
    @(posedge clock); #1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    check("alt_count", 32'(order.size()), 32'd6);
    for (int i = 0; i < order.size() && i < 6; i++) begin
      check($sformatf("alt_order%0d", i), 32'(order[i]), 32'(i % 2));
    end
    tb_grant = 1'b1;

    // Back-to-back fetches on port 1, req kept high across done.
    for (int i = 0; i < 8; i++) begin
      bb[i] = DW'($urandom);
      mem[AW'(32'h100 + i)] = bb[i];
      push(1, 1'b0, AW'(32'h100 + i), bb[i]);
    end
    d0c = done0_cnt;
    prev = -1;
    @(posedge clock); #1;
    drive(1, 1'b1, 1'b0, 20'h00100, '0);
    @(posedge clock);
    for (int i = 0; i < 8; i++) begin
      int seen;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clock);
        if (p1_done) begin seen = 1; break; end
      end
      check($sformatf("bb_done%0d", i), 32'(seen), 32'd1);
      if (prev >= 0) check($sformatf("bb_period%0d", i), 32'(cyc - prev), 32'd4);
      prev = cyc;
      @(posedge clock); #1;
      if (i < 7) p1_addr = AW'(32'h100 + i + 1);
      else       drive(1, 1'b0, 1'b0, '0, '0);
    end
    check("bb_p0_quiet", 32'(done0_cnt - d0c), 32'd0);

    // Reset during CAPTURE of a port 1 read, then re-issue.
    mem[20'h00ABC] = 16'hCAFE;
    @(posedge clock); #1;
    drive(1, 1'b1, 1'b0, 20'h00ABC, '0);
    @(posedge clock);
    @(negedge clock);
    @(negedge clock);
    check("cap_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_strobes", 32'({ram_rden, ram_wren}), 32'd0);
    check("abort_done", 32'({p0_done, p1_done}), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_grant", 32'(grant), 32'd1);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(posedge clock); #1 reset = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    tb_grant = 1'b1;
    do_txn(1, 1'b0, 20'h00ABC, '0, 16'hCAFE, 3);

    // Write/read interleave under both round-robin orders.
    interleave();
    do_txn(0, 1'b0, 20'h00010, '0, 16'hBEEF, 3);
    interleave();

    repeat (4) @(negedge clock);
    check("sb_drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
